// File: rtl/uop_minterm_checker.sv
// rtl/uop_minterm_checker.sv - exhaustive truth-table self-check sequencer for a small combinational gate
//
// Purpose:
//   Walks a minterm counter through every input combination of a small
//   combinational gate, waits a programmable settle time after each change,
//   samples the gate output once and compares it with an expected truth table.
//   The result (pass, mismatch count, lowest failing minterm) is held until
//   the next run, so gate checks can run on hardware as well as in simulation.
//
// Parameters:
//   N_IN    number of gate inputs (1..4); width of mt
//   EXPECT  expected truth table, 2**N_IN bits; bit i is the output for minterm i
//   SETTLE  cycles waited after mt changes before sampling (1..15)
//
// Ports:
//   clk            in   rising-edge clock
//   reset          in   asynchronous active-high reset
//   start          in   begin a run; honoured only when not busy
//   dut_y          in   output of the gate under check
//   mt             out  minterm driven to the gate inputs (MSB = first input)
//   busy           out  run in progress
//   done           out  run finished, results valid until next accepted start
//   pass           out  done with zero mismatches
//   fail_count     out  mismatching minterms in the last run
//   first_fail_mt  out  lowest mismatching minterm (valid when fail_count != 0)

module uop_minterm_checker #(
    parameter int N_IN   = 2,
    parameter     EXPECT = 4'b1001,
    parameter int SETTLE = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            dut_y,
    output logic [N_IN-1:0] mt,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   fail_count,
    output logic [N_IN-1:0] first_fail_mt
);

    localparam int NUM_MT = 1 << N_IN;

    // Bad parameter combinations stop elaboration instead of silently truncating.
    if (N_IN < 1 || N_IN > 4) begin : g_bad_n_in
        $error("uop_minterm_checker: N_IN must be in 1..4");
    end
    if (SETTLE < 1 || SETTLE > 15) begin : g_bad_settle
        $error("uop_minterm_checker: SETTLE must be in 1..15");
    end
    if ($bits(EXPECT) != NUM_MT) begin : g_bad_expect
        $error("uop_minterm_checker: EXPECT width must equal 2**N_IN");
    end

    localparam logic [NUM_MT-1:0] EXPECT_L   = EXPECT;
    localparam logic [3:0]        CNT_RELOAD = 4'(SETTLE - 1);
    localparam logic [N_IN-1:0]   MT_LAST    = '1;
    localparam logic [N_IN-1:0]   MT_ONE     = N_IN'(1);
    localparam logic [N_IN:0]     FAIL_ONE   = (N_IN + 1)'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_CHECK = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_next_state;
    logic [N_IN-1:0] r_mt;
    logic [3:0]      r_cnt;
    logic [N_IN:0]   r_fail_count;
    logic [N_IN-1:0] r_first_fail_mt;

    logic            w_start_accept;
    logic            w_last_mt;
    logic            w_expect_bit;
    logic            w_mismatch;

    // A start is honoured from IDLE and from DONE (restart); ignored while busy.
    assign w_start_accept = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_last_mt      = (r_mt == MT_LAST);
    assign w_expect_bit   = EXPECT_L[r_mt];
    // dut_y is only meaningful in CHECK; the mismatch is never consumed elsewhere.
    assign w_mismatch     = (dut_y != w_expect_bit);

    // FSM: state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM: next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next_state = S_WAIT;
                end
            end
            S_WAIT: begin
                // Counter loaded with SETTLE-1, so WAIT spans exactly SETTLE cycles.
                if (r_cnt == 4'd0) begin
                    w_next_state = S_CHECK;
                end
            end
            S_CHECK: begin
                if (w_last_mt) begin
                    w_next_state = S_DONE;
                end else begin
                    w_next_state = S_WAIT;
                end
            end
            S_DONE: begin
                if (start) begin
                    w_next_state = S_WAIT;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // FSM: output decode
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (r_state)
            S_WAIT:  busy = 1'b1;
            S_CHECK: busy = 1'b1;
            S_DONE:  done = 1'b1;
            default: begin
                busy = 1'b0;
                done = 1'b0;
            end
        endcase
    end

    // Datapath: minterm counter, settle counter and result registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mt            <= '0;
            r_cnt           <= 4'd0;
            r_fail_count    <= '0;
            r_first_fail_mt <= '0;
        end else if (w_start_accept) begin
            r_mt            <= '0;
            r_cnt           <= CNT_RELOAD;
            r_fail_count    <= '0;
            r_first_fail_mt <= '0;
        end else if (r_state == S_WAIT) begin
            if (r_cnt != 4'd0) begin
                r_cnt <= r_cnt - 4'd1;
            end
        end else if (r_state == S_CHECK) begin
            if (w_mismatch) begin
                r_fail_count <= r_fail_count + FAIL_ONE;
                // Minterms are visited in ascending order, so the first
                // recorded mismatch is also the lowest one.
                if (r_fail_count == '0) begin
                    r_first_fail_mt <= r_mt;
                end
            end
            // The run ends on the all-ones minterm; mt never wraps.
            if (!w_last_mt) begin
                r_mt  <= r_mt + MT_ONE;
                r_cnt <= CNT_RELOAD;
            end
        end
    end

    assign mt            = r_mt;
    assign fail_count    = r_fail_count;
    assign first_fail_mt = r_first_fail_mt;
    assign pass          = done && (r_fail_count == '0);

endmodule

// File: tb/tb_uop_minterm_checker.sv
// tb/tb_uop_minterm_checker.sv - directed self-checking bench for uop_minterm_checker

module tb_uop_minterm_checker;

    logic       clk;
    logic       reset;

    // Default instance: 2-input NXOR, SETTLE=2
    logic       start;
    logic       dut_y;
    logic [1:0] mt;
    logic       busy;
    logic       done;
    logic       pass;
    logic [2:0] fail_count;
    logic [1:0] first_fail_mt;
    int         mode;

    // Second instance: 3-input XOR, SETTLE=1
    logic       start3;
    logic       dut_y3;
    logic [2:0] mt3;
    logic       busy3;
    logic       done3;
    logic       pass3;
    logic [3:0] fail_count3;
    logic [2:0] first_fail_mt3;
    int         mode3;

    int total;
    int bad;

    uop_minterm_checker dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .dut_y         (dut_y),
        .mt            (mt),
        .busy          (busy),
        .done          (done),
        .pass          (pass),
        .fail_count    (fail_count),
        .first_fail_mt (first_fail_mt)
    );

    uop_minterm_checker #(
        .N_IN   (3),
        .EXPECT (8'h96),
        .SETTLE (1)
    ) dut3 (
        .clk           (clk),
        .reset         (reset),
        .start         (start3),
        .dut_y         (dut_y3),
        .mt            (mt3),
        .busy          (busy3),
        .done          (done3),
        .pass          (pass3),
        .fail_count    (fail_count3),
        .first_fail_mt (first_fail_mt3)
    );

    // Gate models: 0 = correct NXOR, 1 = stuck-at-0, 2 = XOR (inverted)
    assign dut_y = (mode == 0) ? ~(mt[1] ^ mt[0]) :
                   (mode == 1) ? 1'b0 : (mt[1] ^ mt[0]);
    // 0 = correct 3-input XOR, 1 = wrong only at minterm 5
    assign dut_y3 = (mode3 == 0) ? (^mt3) : ((^mt3) ^ (mt3 == 3'd5));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        mode   = 0;
        mode3  = 0;
        start  = 1'b0;
        start3 = 1'b0;
        reset  = 1'b1;

        // Reset state
        #1;
        check("rst_mt",    32'(mt), 0);
        check("rst_busy",  32'(busy), 0);
        check("rst_done",  32'(done), 0);
        check("rst_pass",  32'(pass), 0);
        check("rst_fail",  32'(fail_count), 0);
        check("rst_first", 32'(first_fail_mt), 0);
        check("rst3_busy", 32'(busy3), 0);
        check("rst3_done", 32'(done3), 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("idle_busy", 32'(busy), 0);

        // Run 1: correct NXOR, one-cycle start pulse
        mode  = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 12; i++) begin
            check("r1_mt",   32'(mt), 32'(i / 3));
            check("r1_busy", 32'(busy), 1);
            check("r1_done", 32'(done), 0);
            @(negedge clk);
        end
        check("r1_done_end", 32'(done), 1);
        check("r1_busy_end", 32'(busy), 0);
        check("r1_pass",     32'(pass), 1);
        check("r1_fail",     32'(fail_count), 0);
        check("r1_mt_end",   32'(mt), 3);

        // Run 2: stuck-at-0, restarted from DONE
        mode  = 1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("r2_done_drop", 32'(done), 0);
        check("r2_busy",      32'(busy), 1);
        check("r2_fail_clr",  32'(fail_count), 0);
        repeat (12) @(negedge clk);
        check("r2_done",  32'(done), 1);
        check("r2_pass",  32'(pass), 0);
        check("r2_fail",  32'(fail_count), 2);
        check("r2_first", 32'(first_fail_mt), 0);

        // Run 3: XOR behaviour, every minterm wrong
        mode  = 2;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (12) @(negedge clk);
        check("r3_done",  32'(done), 1);
        check("r3_pass",  32'(pass), 0);
        check("r3_fail",  32'(fail_count), 4);
        check("r3_first", 32'(first_fail_mt), 0);

        // Mid-run asynchronous reset at mt=2 in WAIT (failing model, counts nonzero)
        mode  = 2;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        check("mr_mt_pre",   32'(mt), 2);
        check("mr_fail_pre", 32'(fail_count), 2);
        check("mr_busy_pre", 32'(busy), 1);
        #1;
        reset = 1'b1;
        #1;
        check("mr_mt",    32'(mt), 0);
        check("mr_busy",  32'(busy), 0);
        check("mr_done",  32'(done), 0);
        check("mr_pass",  32'(pass), 0);
        check("mr_fail",  32'(fail_count), 0);
        check("mr_first", 32'(first_fail_mt), 0);
        reset = 1'b0;
        @(negedge clk);
        check("mr_idle_busy", 32'(busy), 0);
        mode  = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (11) @(negedge clk);
        check("mr_busy_last", 32'(busy), 1);
        check("mr_done_last", 32'(done), 0);
        @(negedge clk);
        check("mr_done_end", 32'(done), 1);
        check("mr_pass_end", 32'(pass), 1);
        check("mr_fail_end", 32'(fail_count), 0);

        // Start held high: first accepted, ignored while busy, auto-restart after one DONE cycle
        mode  = 1;
        start = 1'b1;
        @(negedge clk);
        check("hs_busy0", 32'(busy), 1);
        repeat (5) @(negedge clk);
        check("hs_mt_mid", 32'(mt), 1);
        repeat (7) @(negedge clk);
        check("hs_done1",  32'(done), 1);
        check("hs_fail1",  32'(fail_count), 2);
        check("hs_first1", 32'(first_fail_mt), 0);
        @(negedge clk);
        check("hs_done_drop", 32'(done), 0);
        check("hs_busy_re",   32'(busy), 1);
        check("hs_fail_clr",  32'(fail_count), 0);
        check("hs_mt_re",     32'(mt), 0);
        repeat (12) @(negedge clk);
        start = 1'b0;
        check("hs_done2",  32'(done), 1);
        check("hs_fail2",  32'(fail_count), 2);
        check("hs_first2", 32'(first_fail_mt), 0);
        check("hs_pass2",  32'(pass), 0);
        @(negedge clk);
        check("hs_hold", 32'(done), 1);

        // N_IN=3, EXPECT=8'h96, SETTLE=1: correct model
        mode3  = 0;
        start3 = 1'b1;
        @(negedge clk);
        start3 = 1'b0;
        check("n3_mt0",  32'(mt3), 0);
        check("n3_busy", 32'(busy3), 1);
        repeat (15) @(negedge clk);
        check("n3_busy_last", 32'(busy3), 1);
        check("n3_mt_last",   32'(mt3), 7);
        @(negedge clk);
        check("n3_done", 32'(done3), 1);
        check("n3_pass", 32'(pass3), 1);
        check("n3_fail", 32'(fail_count3), 0);

        // N_IN=3 with a single wrong minterm
        mode3  = 1;
        start3 = 1'b1;
        @(negedge clk);
        start3 = 1'b0;
        repeat (16) @(negedge clk);
        check("n3b_done",  32'(done3), 1);
        check("n3b_pass",  32'(pass3), 0);
        check("n3b_fail",  32'(fail_count3), 1);
        check("n3b_first", 32'(first_fail_mt3), 5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
